// File: rtl/i2c_master_rw.sv
// i2c_master_rw: single-master I2C engine for register writes and reads.
//   Write: S {ADDR,0} SUB [WDATA] P
//   Read : S {ADDR,0} SUB Sr {ADDR,1} <data> NACK P
// Each SCL bit is four quarter periods of D = CLK_Freq/(4*I2C_Freq) clocks.
// Ports:
//   CLK, RESET      system clock, asynchronous active-high reset
//   START           transaction request (rising edge, only while END=1)
//   READ            0 = write, 1 = register read
//   I2C_ADDR        7-bit slave address
//   I2C_WLEN        write only: 1 = sub-address + data, 0 = sub-address only
//   I2C_SUB         register sub-address
//   I2C_WDATA       write data byte
//   I2C_RDATA       byte returned by the last successful read
//   END             1 = idle/done, 0 = busy
//   ACK             1 = slave NACKed a byte of the last transaction
//   I2C_SCL/I2C_SDA open-drain bus lines (driven low or released)
module i2c_master_rw #(
  parameter int CLK_Freq = 50_000_000,
  parameter int I2C_Freq = 20_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       READ,
  input  logic [6:0] I2C_ADDR,
  input  logic       I2C_WLEN,
  input  logic [7:0] I2C_SUB,
  input  logic [7:0] I2C_WDATA,
  output logic [7:0] I2C_RDATA,
  output logic       END,
  output logic       ACK,
  output wire        I2C_SCL,
  inout  wire        I2C_SDA
);

  localparam int D  = CLK_Freq / (4 * I2C_Freq);
  localparam int DW = $clog2(D);

  typedef enum logic [2:0] {
    IDLE, STRT, TXBYTE, RXACK, RSTRT, RXBYTE, MNACK, STOP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic            start_q, start_d;
  logic            end_q, end_d;
  logic            ack_q, ack_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            scl_rel_q, scl_rel_d;
  logic            sda_rel_q, sda_rel_d;
  logic            rd_q, rd_d;
  logic [6:0]      addr_q, addr_d;
  logic            wlen_q, wlen_d;
  logic [7:0]      sub_q, sub_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      shift_q, shift_d;
  logic            tick;
  logic            sda_in;

  assign tick   = (div_q == DW'(D - 1));
  assign sda_in = I2C_SDA;

  // Bus levels per state and quarter, returned as {scl_released, sda_released}.
  function automatic logic [1:0] bus_rel(input state_t st, input logic [1:0] q,
                                         input logic msb);
    logic scl_r, sda_r;
    scl_r = 1'b1;
    sda_r = 1'b1;
    case (st)
      STRT: begin
        scl_r = (q != 2'd3);
        sda_r = (q < 2'd2);
      end
      TXBYTE: begin
        scl_r = (q == 2'd1) || (q == 2'd2);
        sda_r = msb;
      end
      RXACK, RXBYTE, MNACK: begin
        scl_r = (q == 2'd1) || (q == 2'd2);
      end
      RSTRT: begin
        scl_r = (q == 2'd1) || (q == 2'd2);
        sda_r = (q < 2'd2);
      end
      STOP: begin
        scl_r = (q != 2'd0);
        sda_r = (q >= 2'd2);
      end
      default: ;
    endcase
    return {scl_r, sda_r};
  endfunction

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    start_d = START;
    end_d   = end_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wlen_d  = wlen_q;
    sub_d   = sub_q;
    wdata_d = wdata_q;
    shift_d = shift_q;

    if (state_q == IDLE) begin
      div_d = '0;
      if (START && !start_q) begin
        rd_d    = READ;
        addr_d  = I2C_ADDR;
        wlen_d  = I2C_WLEN;
        sub_d   = I2C_SUB;
        wdata_d = I2C_WDATA;
        ack_d   = 1'b0;
        end_d   = 1'b0;
        qtr_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
        state_d = STRT;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
        case (state_q)
          STRT: if (qtr_q == 2'd3) begin
            shift_d = {addr_q, 1'b0};
            state_d = TXBYTE;
          end
          TXBYTE: if (qtr_q == 2'd3) begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RXACK;
          end
          RXACK: begin
            if (qtr_q == 2'd2 && sda_in) ack_d = 1'b1;
            // ack_q is cleared at transaction start and only ever set by a
            // NACK, so seeing it here means this byte was refused.
            if (qtr_q == 2'd3) begin
              byte_d = byte_q + 2'd1;
              if (ack_q) begin
                state_d = STOP;
              end else begin
                case (byte_q)
                  2'd0: begin
                    shift_d = sub_q;
                    state_d = TXBYTE;
                  end
                  2'd1: begin
                    if (rd_q) begin
                      state_d = RSTRT;
                    end else if (wlen_q) begin
                      shift_d = wdata_q;
                      state_d = TXBYTE;
                    end else begin
                      state_d = STOP;
                    end
                  end
                  default: state_d = rd_q ? RXBYTE : STOP;
                endcase
              end
            end
          end
          RSTRT: if (qtr_q == 2'd3) begin
            shift_d = {addr_q, 1'b1};
            state_d = TXBYTE;
          end
          RXBYTE: begin
            if (qtr_q == 2'd2) shift_d = {shift_q[6:0], sda_in};
            if (qtr_q == 2'd3) begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                rdata_d = shift_q;
                state_d = MNACK;
              end
            end
          end
          MNACK: if (qtr_q == 2'd3) state_d = STOP;
          STOP: if (qtr_q == 2'd3) begin
            end_d   = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Bus lines are registered from the next-state decode so they change
    // on the same edge as the quarter they belong to, without glitches.
    {scl_rel_d, sda_rel_d} = bus_rel(state_d, qtr_d, shift_d[7]);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= 8'h00;
      scl_rel_q <= 1'b1;
      sda_rel_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      start_q   <= start_d;
      end_q     <= end_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      scl_rel_q <= scl_rel_d;
      sda_rel_q <= sda_rel_d;
    end
  end

  // Latched request fields and the shift register carry no reset; they are
  // always loaded before use.
  always_ff @(posedge CLK) begin
    rd_q    <= rd_d;
    addr_q  <= addr_d;
    wlen_q  <= wlen_d;
    sub_q   <= sub_d;
    wdata_q <= wdata_d;
    shift_q <= shift_d;
  end

  assign I2C_SCL   = scl_rel_q ? 1'bz : 1'b0;
  assign I2C_SDA   = sda_rel_q ? 1'bz : 1'b0;
  assign I2C_RDATA = rdata_q;
  assign END       = end_q;
  assign ACK       = ack_q;

endmodule

// File: tb/tb_i2c_master_rw.sv
// Bench for i2c_master_rw with D = 4: a cycle-stepped slave model decodes
// the bus, acknowledges (or refuses) bytes, returns read data, and checks
// every byte it receives against a queue of expected bytes.
module tb_i2c_master_rw;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic       READ;
  logic [6:0] I2C_ADDR;
  logic       I2C_WLEN;
  logic [7:0] I2C_SUB;
  logic [7:0] I2C_WDATA;
  wire  [7:0] I2C_RDATA;
  wire        END;
  wire        ACK;
  wire        I2C_SCL;
  wire        I2C_SDA;

  logic slv_low = 1'b0;
  pullup (I2C_SCL);
  pullup (I2C_SDA);
  assign I2C_SDA = slv_low ? 1'b0 : 1'bz;

  i2c_master_rw #(.CLK_Freq(400), .I2C_Freq(25)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .READ(READ),
    .I2C_ADDR(I2C_ADDR), .I2C_WLEN(I2C_WLEN), .I2C_SUB(I2C_SUB),
    .I2C_WDATA(I2C_WDATA), .I2C_RDATA(I2C_RDATA), .END(END), .ACK(ACK),
    .I2C_SCL(I2C_SCL), .I2C_SDA(I2C_SDA)
  );

  always #5 CLK = ~CLK;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_q[$];

  // slave model state
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bitcnt = 0;
  logic [7:0] shreg = 8'h00, txsh = 8'h00, rd_val = 8'h00;
  logic       first = 1'b0, slv_tx = 1'b0, addr_rd = 1'b0;
  logic       nack_addr = 1'b0, mnack_seen = 1'b0;
  int         starts = 0, stops = 0;

  task automatic chk(input string tag, input int got, input int req);
    compared++;
    assert (got === req) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, req);
    end
  endtask

  task automatic check_byte(input logic [7:0] b);
    logic [7:0] e;
    compared++;
    assert (exp_q.size() > 0) else begin
      mismatched++;
      $error("FAIL bus_byte: observed %02h expected none", b);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      assert (b === e) else begin
        mismatched++;
        $error("FAIL bus_byte: observed %02h expected %02h", b, e);
      end
    end
  endtask

  task automatic slave_step();
    logic scl, sda;
    logic [2:0] idx;
    scl = I2C_SCL;
    sda = I2C_SDA;
    if (scl && prev_scl && prev_sda && !sda) begin
      starts++; bitcnt = 0; first = 1'b1; slv_tx = 1'b0; slv_low = 1'b0; addr_rd = 1'b0;
    end else if (scl && prev_scl && !prev_sda && sda) begin
      stops++;
    end else if (scl && !prev_scl) begin
      if (bitcnt < 8 && !slv_tx) shreg = {shreg[6:0], sda};
      if (bitcnt == 8 && slv_tx) mnack_seen = sda;
      bitcnt++;
    end else if (!scl && prev_scl) begin
      if (bitcnt == 8) begin
        if (!slv_tx) begin
          check_byte(shreg);
          if (!(first && nack_addr)) slv_low = 1'b1;
          if (first && shreg[0] && !nack_addr) addr_rd = 1'b1;
        end else begin
          slv_low = 1'b0;
        end
      end else if (bitcnt == 9) begin
        slv_low = 1'b0; bitcnt = 0; first = 1'b0;
        if (slv_tx) begin
          slv_tx = 1'b0;
        end else if (addr_rd) begin
          slv_tx = 1'b1; addr_rd = 1'b0; txsh = rd_val; slv_low = !txsh[7];
        end
      end else if (slv_tx && bitcnt >= 1 && bitcnt <= 7) begin
        idx = 3'(7 - bitcnt);
        slv_low = !txsh[idx];
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  endtask

  task automatic cyc();
    @(negedge CLK);
    slave_step();
  endtask

  task automatic step_count(inout int low);
    cyc();
    if (!END) low++;
  endtask

  task automatic wait_done(inout int low, output bit done);
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step_count(low);
      if (END && low > 0) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_req(input logic rd, input logic [6:0] a, input logic [7:0] s,
                         input logic [7:0] w, input logic wl, input logic nk,
                         input logic [7:0] rv);
    READ = rd; I2C_ADDR = a; I2C_SUB = s; I2C_WDATA = w; I2C_WLEN = wl;
    nack_addr = nk; rd_val = rv; mnack_seen = 1'b0;
    exp_q.push_back({a, 1'b0});
    if (!nk) begin
      exp_q.push_back(s);
      if (rd) exp_q.push_back({a, 1'b1});
      else if (wl) exp_q.push_back(w);
    end
  endtask

  task automatic txn(input string nm, input logic rd, input logic [6:0] a,
                     input logic [7:0] s, input logic [7:0] w, input logic wl,
                     input logic nk, input logic [7:0] rv, input int exp_low,
                     input logic exp_ack);
    int low, st0, sp0;
    bit done;
    set_req(rd, a, s, w, wl, nk, rv);
    st0 = starts; sp0 = stops; low = 0;
    START = 1'b1;
    step_count(low);
    START = 1'b0;
    wait_done(low, done);
    chk({nm, "_done"}, int'(done), 1);
    chk({nm, "_end_low"}, low, exp_low);
    chk({nm, "_ack"}, int'(ACK), int'(exp_ack));
    chk({nm, "_starts"}, starts - st0, (rd && !nk) ? 2 : 1);
    chk({nm, "_stops"}, stops - sp0, 1);
    chk({nm, "_drained"}, exp_q.size(), 0);
    repeat (4) cyc();
  endtask

  initial begin
    int  low, extra, st0;
    bit  done;
    RESET = 1'b1; START = 1'b0; READ = 1'b0; I2C_ADDR = '0; I2C_WLEN = 1'b0;
    I2C_SUB = '0; I2C_WDATA = '0;
    repeat (3) cyc();
    chk("rst_end", int'(END), 1);
    chk("rst_ack", int'(ACK), 0);
    chk("rst_rdata", int'(I2C_RDATA), 8'h00);
    chk("rst_scl", int'(I2C_SCL), 1);
    chk("rst_sda", int'(I2C_SDA), 1);
    RESET = 1'b0;
    repeat (3) cyc();

    txn("wr", 1'b0, 7'h39, 8'h98, 8'h03, 1'b1, 1'b0, 8'h00, 464, 1'b0);
    txn("rd", 1'b1, 7'h39, 8'h42, 8'h00, 1'b0, 1'b0, 8'hA5, 624, 1'b0);
    chk("rd_rdata", int'(I2C_RDATA), 8'hA5);
    chk("rd_master_nack", int'(mnack_seen), 1);
    txn("wr_sub_only", 1'b0, 7'h50, 8'h10, 8'hEE, 1'b0, 1'b0, 8'h00, 320, 1'b0);
    txn("nack", 1'b0, 7'h39, 8'h98, 8'h03, 1'b1, 1'b1, 8'h00, 176, 1'b1);
    chk("nack_rdata_kept", int'(I2C_RDATA), 8'hA5);
    txn("wr_clear", 1'b0, 7'h39, 8'h20, 8'h5A, 1'b1, 1'b0, 8'h00, 464, 1'b0);
    chk("wr_clear_rdata_kept", int'(I2C_RDATA), 8'hA5);
    // Extra START pulse and input changes mid-transfer, then START held high.
    set_req(1'b0, 7'h39, 8'h98, 8'h03, 1'b1, 1'b0, 8'h00);
    st0 = starts; low = 0;
    START = 1'b1;
    repeat (100) step_count(low);
    START = 1'b0; READ = 1'b1; I2C_ADDR = 7'h11; I2C_SUB = 8'h22; I2C_WDATA = 8'h33;
    step_count(low);
    START = 1'b1;
    wait_done(low, done);
    chk("pulse_done", int'(done), 1);
    chk("pulse_end_low", low, 464);
    extra = 0;
    repeat (50) begin
      cyc();
      if (!END) extra++;
    end
    chk("held_no_retrigger", extra, 0);
    chk("pulse_starts", starts - st0, 1);
    chk("pulse_drained", exp_q.size(), 0);
    START = 1'b0;
    repeat (4) cyc();

    // Reset during the first bit of the read data byte.
    set_req(1'b1, 7'h39, 8'h42, 8'h00, 1'b0, 1'b0, 8'hA5);
    START = 1'b1;
    cyc();
    START = 1'b0;
    repeat (465) cyc();
    chk("pre_rst_scl", int'(I2C_SCL), 0);
    chk("pre_rst_end", int'(END), 0);
    RESET = 1'b1;
    #1;
    chk("mid_rst_scl", int'(I2C_SCL), 1);
    chk("mid_rst_sda", int'(I2C_SDA), 1);
    chk("mid_rst_end", int'(END), 1);
    chk("mid_rst_rdata", int'(I2C_RDATA), 8'h00);
    chk("mid_rst_drained", exp_q.size(), 0);
    repeat (2) cyc();
    RESET = 1'b0;
    repeat (2) cyc();
    txn("post_rst", 1'b0, 7'h39, 8'h98, 8'h03, 1'b1, 1'b0, 8'h00, 464, 1'b0);
    chk("post_rst_rdata", int'(I2C_RDATA), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_master_rw.md
I2C_MASTER_RW -- requirements
Module: i2c_master_rw

Interface
REQ-001 SHALL have parameter CLK_Freq, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_Freq, default 20_000, SCL frequency in Hz; quarter-bit divider D = CLK_Freq/(4*I2C_Freq), integer, D>=2.
REQ-003 SHALL have the following ports, one clock and one reset; reset is asynchronous and active-high:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous reset, active-high.
- START  in  1  transaction request; acted on at its rising edge.
- READ  in  1  0 = write transaction, 1 = register read transaction.
- I2C_ADDR  in  7  slave address, for example 7'h39 for the ADV7513.
- I2C_WLEN  in  1  write only: 1 = send sub-address and data; 0 = send sub-address only.
- I2C_SUB  in  8  register sub-address.
- I2C_WDATA  in  8  write data byte.
- I2C_RDATA  out  8  byte returned by the last successful read.
- END  out  1  1 = idle or done; 0 = busy.
- ACK  out  1  1 = the slave NACKed at least one byte of the last transaction (error).
- I2C_SCL  out  1  open-drain clock; driven to 0 or released to 1'bZ.
- I2C_SDA  inout  1  open-drain data; driven to 0 or released to 1'bZ.

Function
REQ-004 SHALL generate a one-cycle quarter tick every D clocks, counting only while busy; each SCL bit SHALL take 4 quarters (Q0 SCL low and SDA set, Q1 SCL released, Q2 SCL high and SDA sampled at end of quarter, Q3 SCL low).
REQ-005 SHALL have FSM states IDLE, STRT, TXBYTE, RXACK, RSTRT, RXBYTE, MNACK, STOP.
REQ-006 SHALL, in IDLE with END=1, detect a START rising edge (START=1, registered START=0) and on that clock latch all inputs, clear ACK, drive END=0 on the next cycle, and enter STRT.
REQ-007 SHALL ignore START edges and input changes while END=0.
REQ-008 STRT (4 quarters): SDA released and SCL released, then SDA low, then SCL low.
REQ-009 SHALL send a write transaction in this order: {ADDR,0}, SUB, then WDATA if WLEN=1; each byte goes out MSB first in TXBYTE, followed by RXACK.
REQ-010 SHALL send a read transaction in this order:
- {ADDR,0}, then SUB;
- RSTRT (4 quarters: SDA released, SCL released, SDA low, SCL low);
- {ADDR,1};
- RXBYTE, 8 bits sampled MSB first with SDA released;
- MNACK, one bit with SDA released;
- STOP.
REQ-011 RXACK: SHALL release SDA and sample it in Q2; if it reads 1 (NACK), SHALL set ACK=1 and go straight to STOP, skipping the remaining bytes.
REQ-012 STOP (4 quarters): SDA low with SCL low, SCL released, then SDA released; then IDLE with END=1.
REQ-013 SHALL update I2C_RDATA only on entry to MNACK of a read with no NACK; otherwise I2C_RDATA holds its value.
REQ-014 Busy duration: END SHALL be 0 for exactly Qn*D clocks, where Qn = 116 (write, WLEN=1), 80 (write, WLEN=0), or 156 (read); NACK aborts are shorter.
REQ-015 SHALL NOT support clock stretching or arbitration; SDA is never driven to 1.
REQ-016 START held high across completion SHALL NOT retrigger; a new rising edge is required.

Reset
REQ-017 While RESET=1, and asynchronously on its assertion:
- SCL and SDA released (Z);
- END=1, ACK=0, I2C_RDATA=8'h00;
- FSM in IDLE;
- divider, bit counter and registered START all cleared.
REQ-018 Reset asserted mid-transaction SHALL abort immediately with no STOP generated; the first START rising edge after release SHALL begin a fresh transaction.

Verification (bench uses CLK_Freq=400, I2C_Freq=25, so D=4)
REQ-019 Write: ADDR=7'h39, SUB=8'h98, WDATA=8'h03, slave ACKs every byte -> bytes 8'h72, 8'h98, 8'h03 seen on the bus, END low for 464 clocks, ACK=0.
REQ-020 Read: ADDR=7'h39, SUB=8'h42, slave returns 8'hA5 -> bytes 8'h72, 8'h42, repeated start, 8'h73 seen on the bus, master NACK, I2C_RDATA=8'hA5, END low for 624 clocks.
REQ-021 Slave NACKs the address byte on a write -> STOP follows the first RXACK, ACK=1, I2C_RDATA unchanged, and a following good write clears ACK.
REQ-022 START pulsed again mid-transfer, and START held high through completion -> exactly one transaction occurs.
REQ-023 RESET asserted during RXBYTE -> SCL and SDA become Z in the same cycle, END=1, I2C_RDATA=8'h00; a following write completes normally.
